// File: rtl/step_pulse_monitor_if.sv
// -----------------------------------------------------------------------------
// step_pulse_monitor_if
// Groups the CW/CCW step-pulse inputs, the HPS control strobes/limits and the
// decoded results of step_pulse_monitor into one bundle.
//   master : side that drives the pulse lines and control (bench / HPS glue)
//   slave  : the monitor itself
// Signals:
//   CW_in, CCW_in        asynchronous step pulse lines
//   CW_polarity          0: CW = +1 / CCW = -1, 1: inverted
//   load, load_value     one-cycle preload of Position
//   clear_faults         one-cycle clear of the sticky fault flags
//   lower_limit,
//   upper_limit          unsigned allowed Position window
//   Position             reconstructed 32-bit position (wraps)
//   step_strobe,step_dir one-cycle pulse per accepted step and its direction
//   period,period_valid  cycles between the last two accepted steps
//   moving               a step was accepted recently
//   overlap_fault,
//   range_fault          sticky fault flags
// -----------------------------------------------------------------------------
interface step_pulse_monitor_if;
    logic        CW_in;
    logic        CCW_in;
    logic        CW_polarity;
    logic        load;
    logic [31:0] load_value;
    logic        clear_faults;
    logic [31:0] lower_limit;
    logic [31:0] upper_limit;
    logic [31:0] Position;
    logic        step_strobe;
    logic        step_dir;
    logic [31:0] period;
    logic        period_valid;
    logic        moving;
    logic        overlap_fault;
    logic        range_fault;

    modport master (
        output CW_in, CCW_in, CW_polarity, load, load_value, clear_faults,
               lower_limit, upper_limit,
        input  Position, step_strobe, step_dir, period, period_valid, moving,
               overlap_fault, range_fault
    );

    modport slave (
        input  CW_in, CCW_in, CW_polarity, load, load_value, clear_faults,
               lower_limit, upper_limit,
        output Position, step_strobe, step_dir, period, period_valid, moving,
               overlap_fault, range_fault
    );
endinterface

// File: rtl/step_pulse_monitor.sv
// -----------------------------------------------------------------------------
// step_pulse_monitor
// Receive-side decoder for a CW/CCW step-pulse interface. Synchronises and
// glitch-filters both lines, rebuilds a wrapping 32-bit position, measures the
// inter-step period and flags overlap / out-of-range faults.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : step_pulse_monitor_if.slave (pulse lines, control, results)
// -----------------------------------------------------------------------------
module step_pulse_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int STALL_CYCLES  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    step_pulse_monitor_if.slave   bus
);
    // Cycles after reset until a filtered line reflects only real input.
    localparam int FLUSH   = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int FLUSH_W = $clog2(FLUSH + 1);

    typedef enum logic [1:0] {IDLE, CW_HIGH, CCW_HIGH, FAULT} state_t;

    logic [SYNC_STAGES-1:0]   r_cw_sync, r_ccw_sync;
    logic [FILTER_CYCLES-1:0] r_cw_hist, r_ccw_hist;
    logic                     r_cw_filt, r_ccw_filt;
    logic                     r_cw_armed, r_ccw_armed;
    logic [FLUSH_W-1:0]       r_flush;

    state_t      r_state;
    logic [31:0] r_pos, r_gap, r_period;
    logic        r_step_strobe, r_step_dir, r_period_valid, r_moving;
    logic        r_have_prev, r_overlap, r_range;

    logic        w_cw, w_ccw, w_step_cw, w_step_ccw, w_step, w_inc;
    logic        w_range_set, w_overlap_set;
    logic [31:0] w_pos_step, w_new_pos;

    // Synchroniser chain and filter. The filtered line only changes once the
    // whole history window agrees, i.e. FILTER_CYCLES identical samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cw_sync   <= '0;
            r_ccw_sync  <= '0;
            r_cw_hist   <= '0;
            r_ccw_hist  <= '0;
            r_cw_filt   <= 1'b0;
            r_ccw_filt  <= 1'b0;
            r_cw_armed  <= 1'b0;
            r_ccw_armed <= 1'b0;
            r_flush     <= '0;
        end else begin
            r_cw_sync  <= (r_cw_sync << 1) | SYNC_STAGES'(bus.CW_in);
            r_ccw_sync <= (r_ccw_sync << 1) | SYNC_STAGES'(bus.CCW_in);
            r_cw_hist  <= (r_cw_hist << 1) | FILTER_CYCLES'(r_cw_sync[SYNC_STAGES-1]);
            r_ccw_hist <= (r_ccw_hist << 1) | FILTER_CYCLES'(r_ccw_sync[SYNC_STAGES-1]);
            if (&r_cw_hist)       r_cw_filt <= 1'b1;
            else if (~|r_cw_hist) r_cw_filt <= 1'b0;
            if (&r_ccw_hist)       r_ccw_filt <= 1'b1;
            else if (~|r_ccw_hist) r_ccw_filt <= 1'b0;
            // A line held high across reset must first be seen low with real
            // data in the pipeline before its rising edge can count.
            if (r_flush != FLUSH_W'(FLUSH)) begin
                r_flush <= r_flush + FLUSH_W'(1);
            end else begin
                if (!r_cw_filt)  r_cw_armed  <= 1'b1;
                if (!r_ccw_filt) r_ccw_armed <= 1'b1;
            end
        end
    end

    assign w_cw       = r_cw_filt & r_cw_armed;
    assign w_ccw      = r_ccw_filt & r_ccw_armed;
    // IDLE is only entered with the lines low, so a high level there is a rise.
    assign w_step_cw  = (r_state == IDLE) && w_cw && !w_ccw;
    assign w_step_ccw = (r_state == IDLE) && w_ccw && !w_cw;
    assign w_step     = w_step_cw | w_step_ccw;
    assign w_inc      = w_step_cw ^ bus.CW_polarity;
    assign w_pos_step = w_inc ? r_pos + 32'd1 : r_pos - 32'd1;
    assign w_new_pos  = bus.load ? bus.load_value : w_pos_step;
    assign w_range_set = (bus.load | w_step) &
                         ((w_new_pos < bus.lower_limit) | (w_new_pos > bus.upper_limit));
    // Both lines high outside FAULT covers the simultaneous rise in IDLE as
    // well as the other line rising while one is held.
    assign w_overlap_set = (r_state != FAULT) && w_cw && w_ccw;

    // Direction FSM, position, period and fault tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pos          <= '0;
            r_gap          <= '0;
            r_period       <= '0;
            r_step_strobe  <= 1'b0;
            r_step_dir     <= 1'b0;
            r_period_valid <= 1'b0;
            r_moving       <= 1'b0;
            r_have_prev    <= 1'b0;
            r_overlap      <= 1'b0;
            r_range        <= 1'b0;
        end else begin
            r_step_strobe <= w_step;
            case (r_state)
                IDLE: begin
                    if (w_cw && w_ccw) r_state <= FAULT;
                    else if (w_cw)     r_state <= CW_HIGH;
                    else if (w_ccw)    r_state <= CCW_HIGH;
                end
                CW_HIGH: begin
                    if (!w_cw)      r_state <= IDLE;
                    else if (w_ccw) r_state <= FAULT;
                end
                CCW_HIGH: begin
                    if (!w_ccw)    r_state <= IDLE;
                    else if (w_cw) r_state <= FAULT;
                end
                FAULT: begin
                    if (!w_cw && !w_ccw) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // New faults take priority over a simultaneous clear.
            r_overlap <= w_overlap_set | (r_overlap & ~bus.clear_faults);
            r_range   <= w_range_set | (r_range & ~bus.clear_faults);

            if (r_gap != 32'hFFFF_FFFF) r_gap <= r_gap + 32'd1;

            if (bus.load) begin
                // A step on the same edge is discarded; only the strobe remains.
                r_pos          <= bus.load_value;
                r_gap          <= '0;
                r_period_valid <= 1'b0;
                r_have_prev    <= 1'b0;
            end else if (w_step) begin
                r_pos          <= w_pos_step;
                r_step_dir     <= w_inc;
                r_period       <= (r_gap == 32'hFFFF_FFFF) ? r_gap : r_gap + 32'd1;
                r_gap          <= '0;
                r_period_valid <= r_have_prev && (r_step_dir == w_inc);
                r_have_prev    <= 1'b1;
                r_moving       <= 1'b1;
            end else if (r_gap == 32'(STALL_CYCLES - 1)) begin
                r_moving       <= 1'b0;
                r_period_valid <= 1'b0;
            end
        end
    end

    assign bus.Position      = r_pos;
    assign bus.step_strobe   = r_step_strobe;
    assign bus.step_dir      = r_step_dir;
    assign bus.period        = r_period;
    assign bus.period_valid  = r_period_valid;
    assign bus.moving        = r_moving;
    assign bus.overlap_fault = r_overlap;
    assign bus.range_fault   = r_range;
endmodule

// File: tb/tb_step_pulse_monitor.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_monitor
// Directed and randomized pulse trains against a transaction-level model of
// the step decoder (pulse accepted/rejected, position, period, faults).
// -----------------------------------------------------------------------------
module tb_step_pulse_monitor;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int STALL = 1000;
    localparam int LAT   = SYNC + FILT + 2;  // drive cycle -> strobe cycle

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    step_pulse_monitor_if bus();

    step_pulse_monitor #(
        .SYNC_STAGES  (SYNC),
        .FILTER_CYCLES(FILT),
        .STALL_CYCLES (STALL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_strobe   = 0;
    int   strobe_cyc = 0;
    int   fall_cyc   = 0;
    logic mov_q      = 1'b0;
    always @(negedge clk) begin
        if (bus.step_strobe === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
        end
        if (mov_q === 1'b1 && bus.moving === 1'b0) fall_cyc = cyc;
        mov_q = bus.moving;
    end

    // Reference model state
    logic [31:0] m_pos, m_period, m_lo, m_hi;
    bit          m_dir, m_valid, m_have_prev, m_moving, m_ovl, m_rng;
    int          m_cnt = 0;
    int          m_gap0 = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Movement stops STALL cycles after the last step or load with no step.
    task automatic apply_stall(input int e);
        if (m_moving && e >= m_gap0 + STALL) begin
            m_moving = 1'b0;
            m_valid  = 1'b0;
        end
    endtask

    task automatic range_upd();
        if (m_pos < m_lo || m_pos > m_hi) m_rng = 1'b1;
    endtask

    task automatic m_step(input bit is_cw, input int rise_c);
        int se;
        bit inc;
        se  = rise_c + LAT;
        inc = is_cw ^ bus.CW_polarity;
        apply_stall(se - 1);
        m_cnt++;
        m_valid     = m_have_prev && (inc == m_dir);
        m_pos       = inc ? m_pos + 32'd1 : m_pos - 32'd1;
        m_dir       = inc;
        m_have_prev = 1'b1;
        m_period    = 32'(se - m_gap0);
        m_gap0      = se;
        m_moving    = 1'b1;
        range_upd();
    endtask

    task automatic check_all(input string tag);
        apply_stall(cyc);
        chk({tag, "_pos"},     bus.Position,             m_pos);
        chk({tag, "_strobes"}, 32'(n_strobe),            32'(m_cnt));
        chk({tag, "_dir"},     32'(bus.step_dir),        32'(m_dir));
        chk({tag, "_period"},  bus.period,               m_period);
        chk({tag, "_pvalid"},  32'(bus.period_valid),    32'(m_valid));
        chk({tag, "_moving"},  32'(bus.moving),          32'(m_moving));
        chk({tag, "_ovl"},     32'(bus.overlap_fault),   32'(m_ovl));
        chk({tag, "_rng"},     32'(bus.range_fault),     32'(m_rng));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        m_pos = '0; m_period = '0; m_dir = 1'b0; m_valid = 1'b0;
        m_have_prev = 1'b0; m_moving = 1'b0; m_ovl = 1'b0; m_rng = 1'b0;
        m_gap0 = cyc;
    endtask

    task automatic do_load(input logic [31:0] v);
        bus.load = 1'b1;
        bus.load_value = v;
        tick(1);
        bus.load = 1'b0;
        apply_stall(cyc - 1);
        m_pos = v; m_gap0 = cyc; m_valid = 1'b0; m_have_prev = 1'b0;
        range_upd();
    endtask

    task automatic do_clear();
        bus.clear_faults = 1'b1;
        tick(1);
        bus.clear_faults = 1'b0;
        m_ovl = 1'b0;
        m_rng = 1'b0;
    endtask

    task automatic set_limits(input logic [31:0] lo, input logic [31:0] hi);
        bus.lower_limit = lo; bus.upper_limit = hi;
        m_lo = lo; m_hi = hi;
    endtask

    task automatic pulse(input bit cw, input bit ccw, input int hi, input int lo);
        int rc;
        bus.CW_in  = cw;
        bus.CCW_in = ccw;
        rc = cyc;
        tick(hi);
        bus.CW_in  = 1'b0;
        bus.CCW_in = 1'b0;
        tick(lo);
        if (hi >= FILT && (cw ^ ccw)) m_step(cw, rc);
        if (hi >= FILT && cw && ccw) m_ovl = 1'b1;
    endtask

    initial begin
        int t0, t_se, k, rc;
        bus.CW_in = 1'b0; bus.CCW_in = 1'b0; bus.CW_polarity = 1'b0;
        bus.load = 1'b0; bus.load_value = '0; bus.clear_faults = 1'b0;
        set_limits(32'd0, 32'hFFFF_FFFF);
        rst = 1'b1;

        // Reset state
        do_reset(3);
        chk("reset_strobe", 32'(bus.step_strobe), 32'd0);
        check_all("reset");
        tick(20);

        // Five CW pulses from 1000, polarity 0
        bus.CW_polarity = 1'b0;
        do_load(32'd1000);
        t0 = cyc;
        pulse(1, 0, 10, 500);
        chk("latency", 32'(strobe_cyc - t0), 32'(LAT));
        for (int i = 0; i < 4; i++) pulse(1, 0, 10, 500);
        chk("t1_pos",    bus.Position, 32'd1005);
        chk("t1_period", bus.period,   32'd510);
        chk("t1_pvalid", 32'(bus.period_valid), 32'd1);
        check_all("t1");

        // Inverted polarity: CCW counts up, then one CW reversal
        bus.CW_polarity = 1'b1;
        do_load(32'd0);
        for (int i = 0; i < 3; i++) pulse(0, 1, 10, 200);
        chk("t2_pos3", bus.Position, 32'd3);
        pulse(1, 0, 10, 200);
        chk("t2_pos2", bus.Position, 32'd2);
        chk("t2_pvalid", 32'(bus.period_valid), 32'd0);
        check_all("t2");

        // Glitch narrower than the filter
        bus.CW_polarity = 1'b0;
        pulse(1, 0, 3, 50);
        check_all("t3");

        // Overlap fault, clear, recovery
        pulse(1, 1, 20, 50);
        chk("t4_ovl", 32'(bus.overlap_fault), 32'd1);
        check_all("t4a");
        do_clear();
        check_all("t4b");
        pulse(1, 0, 10, 50);
        check_all("t4c");

        // Range window and wrap
        set_limits(32'd100, 32'd200);
        do_load(32'd200);
        check_all("t5a");
        pulse(1, 0, 10, 50);
        chk("t5_pos", bus.Position, 32'd201);
        chk("t5_rng", 32'(bus.range_fault), 32'd1);
        check_all("t5b");
        do_clear();
        check_all("t5c");
        do_load(32'hFFFF_FFFF);
        pulse(1, 0, 10, 50);
        chk("t5_wrap", bus.Position, 32'd0);
        check_all("t5d");
        set_limits(32'd0, 32'hFFFF_FFFF);
        do_clear();
        check_all("t5e");

        // Stall detection
        pulse(1, 0, 10, 20);
        t_se = strobe_cyc;
        k = 0;
        while (fall_cyc <= t_se && k < STALL + 200) begin
            tick(1);
            k++;
        end
        chk("t6_stall", 32'(fall_cyc - t_se), 32'(STALL));
        chk("t6_pvalid", 32'(bus.period_valid), 32'd0);
        check_all("t6");

        // Reset while CW is held high
        rc = cyc;
        bus.CW_in = 1'b1;
        tick(30);
        m_step(1, rc);
        check_all("t7a");
        do_reset(2);
        check_all("t7b");
        tick(100);
        check_all("t7c");
        bus.CW_in = 1'b0;
        tick(40);
        check_all("t7d");
        pulse(1, 0, 10, 30);
        chk("t7_pos", bus.Position, 32'd1);
        check_all("t7e");

        // Randomized pulse trains
        for (int i = 0; i < 24; i++) begin
            bit cw;
            bus.CW_polarity = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) do_load($urandom);
            cw = 1'($urandom_range(0, 1));
            pulse(cw, !cw, $urandom_range(1, 12), $urandom_range(20, 300));
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
